// File: rtl/activation_streamer_pkg.sv
// activation_streamer_pkg
//   Shared types and widths for the activation streamer.
//   MatrixBits : width of the unpadded matrix edge M
//   PadBits    : width of the pad width p (0..3)
//   EdgeBits   : width of the padded edge P = M + 2p and of the row/col counters
//   state_e    : streamer FSM states
package activation_streamer_pkg;

  localparam int MatrixBits = 14;
  localparam int PadBits    = 2;
  localparam int EdgeBits   = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/pad_index_gen.sv
// pad_index_gen
//   Raster row/col counters over the padded matrix, flagging padding
//   positions and the final position.
//   clk_i       : clock
//   rst_i       : synchronous active-low reset
//   clear       : restart the raster at (0,0)
//   advance     : step to the next raster position
//   matrix_size : unpadded edge M (held stable for the whole run)
//   padding     : pad width p (held stable for the whole run)
//   is_pad      : current position lies in the zero border
//   last        : current position is (P-1,P-1)
module pad_index_gen
  import activation_streamer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear,
  input  logic                  advance,
  input  logic [MatrixBits-1:0] matrix_size,
  input  logic [PadBits-1:0]    padding,
  output logic                  is_pad,
  output logic                  last
);

  logic [EdgeBits-1:0] row_q;
  logic [EdgeBits-1:0] col_q;
  logic [EdgeBits-1:0] pad_lo;
  logic [EdgeBits-1:0] pad_hi;
  logic [EdgeBits-1:0] edge_last;

  // Interior occupies [p, p+M) on both axes; P-1 = p + M + p - 1.
  assign pad_lo    = EdgeBits'(padding);
  assign pad_hi    = pad_lo + EdgeBits'(matrix_size);
  assign edge_last = pad_hi + pad_lo - EdgeBits'(1);

  assign is_pad = (row_q < pad_lo) || (row_q >= pad_hi) ||
                  (col_q < pad_lo) || (col_q >= pad_hi);
  assign last   = (row_q == edge_last) && (col_q == edge_last);

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (advance) begin
      if (col_q == edge_last) begin
        col_q <= '0;
        row_q <= row_q + EdgeBits'(1);
      end else begin
        col_q <= col_q + EdgeBits'(1);
      end
    end
  end

endmodule

// File: rtl/activation_streamer.sv
// activation_streamer
//   Streams an M x M activation matrix out of a single-port BRAM in raster
//   order with p zero elements of padding on every side. Padding costs no
//   memory reads. hold_i pauses issue without losing elements.
//   clk_i             : clock
//   rst_i             : synchronous active-low reset
//   start_i           : start request, honoured only when idle
//   matrix_size_i     : unpadded edge M, latched on start
//   padding_i         : pad width p, latched on start
//   base_addr_i       : BRAM address of element (0,0), latched on start
//   hold_i            : suppress the issue in this cycle
//   mem_addr_o        : BRAM read address
//   mem_re_o          : BRAM read enable
//   mem_data_i        : BRAM read data, one cycle after mem_re_o
//   activation_data_o : element to the convolution layer
//   run_o             : activation_data_o valid this cycle
//   busy_o            : run in progress (start accepted through done)
//   done_o            : one-cycle pulse after the last element
module activation_streamer
  import activation_streamer_pkg::*;
#(
  parameter int N             = 16,
  parameter int MaxMatrixSize = 16383,
  parameter int AddrBits      = 28
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [MatrixBits-1:0] matrix_size_i,
  input  logic [PadBits-1:0]    padding_i,
  input  logic [AddrBits-1:0]   base_addr_i,
  input  logic                  hold_i,
  output logic [AddrBits-1:0]   mem_addr_o,
  output logic                  mem_re_o,
  input  logic [N-1:0]          mem_data_i,
  output logic signed [N-1:0]   activation_data_o,
  output logic                  run_o,
  output logic                  busy_o,
  output logic                  done_o
);

  if (MaxMatrixSize >= (1 << MatrixBits)) begin : g_size_check
    $error("MaxMatrixSize does not fit in matrix_size_i");
  end

  state_e                 state_q;
  logic [MatrixBits-1:0]  m_q;
  logic [PadBits-1:0]     p_q;
  logic [AddrBits-1:0]    addr_q;
  logic                   issue;
  logic                   start_ok;
  logic                   is_pad;
  logic                   last;
  logic                   vld_p1;
  logic                   pad_p1;
  logic signed [N-1:0]    held_p1;

  assign start_ok = (state_q == ST_IDLE) && start_i;
  assign issue    = (state_q == ST_ISSUE) && !hold_i;

  pad_index_gen u_index (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear       (start_ok),
    .advance     (issue),
    .matrix_size (m_q),
    .padding     (p_q),
    .is_pad      (is_pad),
    .last        (last)
  );

  assign mem_re_o   = issue && !is_pad;
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);

  // ---- stage 1: present the element issued last cycle ----
  // BRAM data arrives combinationally in this cycle, so stage 1 registers
  // only the valid/pad flags; the held register keeps the output steady
  // through bubbles.
  assign run_o             = vld_p1;
  assign activation_data_o = !vld_p1 ? held_p1 :
                             pad_p1  ? '0      : $signed(mem_data_i);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      p_q     <= '0;
      addr_q  <= '0;
      vld_p1  <= 1'b0;
      pad_p1  <= 1'b0;
      held_p1 <= '0;
    end else begin
      vld_p1 <= issue;
      pad_p1 <= is_pad;
      if (vld_p1) begin
        held_p1 <= activation_data_o;
      end
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            m_q     <= matrix_size_i;
            p_q     <= padding_i;
            addr_q  <= base_addr_i;
            // An empty matrix has nothing to issue, even when padded.
            state_q <= (matrix_size_i == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue) begin
            if (!is_pad) begin
              addr_q <= addr_q + AddrBits'(1);
            end
            if (last) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: state_q <= ST_DONE;
        ST_DONE:  state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_activation_streamer.sv
// tb_activation_streamer
//   Table-driven bench for activation_streamer: each record gives a job
//   (M, p, base, optional hold window, optional stray start) and the
//   hand-computed outcome (output sequence, read count, bubble count,
//   done cycle). Reset behaviour is exercised by hand-written sequences.
module tb_activation_streamer;

  localparam int N        = 16;
  localparam int AddrBits = 28;
  localparam int NV       = 7;

  logic                clk = 1'b0;
  logic                rst_i = 1'b0;
  logic                start_i = 1'b0;
  logic [13:0]         matrix_size_i = '0;
  logic [1:0]          padding_i = '0;
  logic [AddrBits-1:0] base_addr_i = '0;
  logic                hold_i = 1'b0;
  logic [AddrBits-1:0] mem_addr_o;
  logic                mem_re_o;
  logic [N-1:0]        mem_data_i = '0;
  logic signed [N-1:0] activation_data_o;
  logic                run_o;
  logic                busy_o;
  logic                done_o;

  activation_streamer #(.N(N), .MaxMatrixSize(16383), .AddrBits(AddrBits)) dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .matrix_size_i     (matrix_size_i),
    .padding_i         (padding_i),
    .base_addr_i       (base_addr_i),
    .hold_i            (hold_i),
    .mem_addr_o        (mem_addr_o),
    .mem_re_o          (mem_re_o),
    .mem_data_i        (mem_data_i),
    .activation_data_o (activation_data_o),
    .run_o             (run_o),
    .busy_o            (busy_o),
    .done_o            (done_o)
  );

  always #5 clk = ~clk;

  // BRAM model: 256 words, addressed by the low address byte.
  logic [N-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_re_o) mem_data_i <= mem[mem_addr_o[7:0]];
  end

  typedef struct {
    int                  m;
    int                  p;
    logic [AddrBits-1:0] base;
    int                  hold_cyc;
    int                  hold_len;
    int                  inj_cyc;
    int                  exp_runs;
    int                  exp_reads;
    int                  exp_gaps;
    int                  exp_done;
  } vec_t;

  vec_t v [NV];
  int   exp_data [NV][16];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_job(input int vi);
    int cyc, runs, reads, gaps, done_cyc, busy_cyc;
    bit seen;
    logic [AddrBits-1:0] exp_addr;
    runs = 0; reads = 0; gaps = 0; done_cyc = -1; busy_cyc = 0; seen = 1'b0;
    exp_addr = v[vi].base;
    @(negedge clk);
    matrix_size_i = 14'(v[vi].m);
    padding_i     = 2'(v[vi].p);
    base_addr_i   = v[vi].base;
    hold_i        = 1'b0;
    start_i       = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (done_cyc < 0 && cyc < 200) begin
      hold_i = (v[vi].hold_len > 0) && (cyc >= v[vi].hold_cyc) &&
               (cyc < v[vi].hold_cyc + v[vi].hold_len);
      if (v[vi].inj_cyc == cyc) begin
        start_i       = 1'b1;
        matrix_size_i = 14'd5;
        base_addr_i   = 28'h99;
      end else begin
        start_i = 1'b0;
      end
      #1;
      if (busy_o) busy_cyc++;
      if (mem_re_o) begin
        check($sformatf("job%0d read addr %0d", vi, reads), 32'(mem_addr_o), 32'(exp_addr));
        exp_addr = exp_addr + 28'd1;
        reads++;
      end
      if (run_o) begin
        if (runs < 16)
          check($sformatf("job%0d data %0d", vi, runs), 32'(activation_data_o[15:0]),
                32'(exp_data[vi][runs][15:0]));
        seen = 1'b1;
        runs++;
      end else if (busy_o && !done_o && seen) begin
        gaps++;
        check($sformatf("job%0d held data", vi), 32'(activation_data_o[15:0]),
              32'(exp_data[vi][runs-1][15:0]));
      end
      if (done_o) done_cyc = cyc;
      @(negedge clk);
      cyc++;
    end
    hold_i  = 1'b0;
    start_i = 1'b0;
    check($sformatf("job%0d done seen", vi), 32'(done_cyc >= 0), 32'd1);
    check($sformatf("job%0d run count", vi), 32'(runs), 32'(v[vi].exp_runs));
    check($sformatf("job%0d read count", vi), 32'(reads), 32'(v[vi].exp_reads));
    check($sformatf("job%0d gap count", vi), 32'(gaps), 32'(v[vi].exp_gaps));
    check($sformatf("job%0d done cycle", vi), 32'(done_cyc), 32'(v[vi].exp_done));
    check($sformatf("job%0d busy cycles", vi), 32'(busy_cyc), 32'(v[vi].exp_done));
    #1;
    check($sformatf("job%0d idle after done", vi), {29'd0, busy_o, done_o, run_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int extra_done;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < 9; i++) mem[8'h10 + i] = 16'(i + 1);
    mem[8'h40] = 16'd5; mem[8'h41] = 16'd6; mem[8'h42] = 16'd7; mem[8'h43] = 16'd8;
    mem[8'h80] = 16'h8001;
    mem[8'hFF] = 16'd11; mem[8'h00] = 16'd12; mem[8'h01] = 16'd13; mem[8'h02] = 16'd14;

    v[0] = '{m:3, p:0, base:28'h10, hold_cyc:0, hold_len:0, inj_cyc:0,
             exp_runs:9, exp_reads:9, exp_gaps:0, exp_done:11};
    v[1] = '{m:2, p:1, base:28'h40, hold_cyc:0, hold_len:0, inj_cyc:0,
             exp_runs:16, exp_reads:4, exp_gaps:0, exp_done:18};
    v[2] = '{m:3, p:0, base:28'h10, hold_cyc:5, hold_len:2, inj_cyc:0,
             exp_runs:9, exp_reads:9, exp_gaps:2, exp_done:13};
    v[3] = '{m:3, p:0, base:28'h10, hold_cyc:0, hold_len:0, inj_cyc:4,
             exp_runs:9, exp_reads:9, exp_gaps:0, exp_done:11};
    v[4] = '{m:0, p:2, base:28'h20, hold_cyc:0, hold_len:0, inj_cyc:0,
             exp_runs:0, exp_reads:0, exp_gaps:0, exp_done:2};
    v[5] = '{m:1, p:1, base:28'h80, hold_cyc:0, hold_len:0, inj_cyc:0,
             exp_runs:9, exp_reads:1, exp_gaps:0, exp_done:11};
    v[6] = '{m:2, p:0, base:28'hFFFFFFF, hold_cyc:0, hold_len:0, inj_cyc:0,
             exp_runs:4, exp_reads:4, exp_gaps:0, exp_done:6};

    exp_data[0] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
    exp_data[1] = '{0, 0, 0, 0, 0, 5, 6, 0, 0, 7, 8, 0, 0, 0, 0, 0};
    exp_data[2] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
    exp_data[3] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
    exp_data[4] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_data[5] = '{0, 0, 0, 0, 32'h8001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    exp_data[6] = '{11, 12, 13, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    // Reset state.
    rst_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset run_o", 32'(run_o), 32'd0);
    check("reset mem_re_o", 32'(mem_re_o), 32'd0);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset done_o", 32'(done_o), 32'd0);
    check("reset data", 32'(activation_data_o[15:0]), 32'd0);
    check("reset addr", 32'(mem_addr_o), 32'd0);

    // Reset and start together: reset wins.
    @(negedge clk);
    matrix_size_i = 14'd3; padding_i = 2'd0; base_addr_i = 28'h10; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; rst_i = 1'b1;
    #1;
    check("reset beats start busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    #1;
    check("reset beats start still idle", 32'(busy_o), 32'd0);

    for (int i = 0; i < NV; i++) run_job(i);

    // Mid-stream reset after the 5th output of an M=3 job.
    @(negedge clk);
    matrix_size_i = 14'd3; padding_i = 2'd0; base_addr_i = 28'h10; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);   // now mid cycle 6
    #1;
    check("midreset 5th output valid", 32'(run_o), 32'd1);
    check("midreset 5th output data", 32'(activation_data_o[15:0]), 32'd5);
    @(negedge clk);
    rst_i = 1'b0;                // low through the edge ending cycle 7
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("midreset run_o", 32'(run_o), 32'd0);
    check("midreset mem_re_o", 32'(mem_re_o), 32'd0);
    check("midreset busy_o", 32'(busy_o), 32'd0);
    check("midreset done_o", 32'(done_o), 32'd0);
    check("midreset data", 32'(activation_data_o[15:0]), 32'd0);
    check("midreset addr", 32'(mem_addr_o), 32'd0);
    extra_done = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      if (done_o || run_o || busy_o) extra_done++;
    end
    check("midreset no completion", 32'(extra_done), 32'd0);

    run_job(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/activation_streamer.md
# activation_streamer

Reads an activation matrix from a single-port BRAM and streams it in raster order, one element per cycle, into the convolution layer's `activation_data_i` / `run_i` input. It inserts the requested zero padding on all four sides, so padded elements cost no memory reads. It is the producer end of the convolution layer's activation stream. A hold input lets the controller pause the stream without losing elements.

## Interface
- `N`, 16, activation data width
- `MaxMatrixSize`, 16383, largest unpadded matrix edge; `matrix_size_i` is 14 bits
- `AddrBits`, 28, BRAM word-address width

Ports:
- `clk_i`  in  1  clock; one clock domain
- `rst_i`  in  1  reset, synchronous, active-low
- `start_i`  in  1  start request; sampled only in IDLE
- `matrix_size_i`  in  14  unpadded edge M; latched on accepted start
- `padding_i`  in  2  pad width p (0..3); latched on accepted start
- `base_addr_i`  in  AddrBits  address of element (0,0); latched on accepted start
- `hold_i`  in  1  pause issue this cycle
- `mem_addr_o`  out  AddrBits  BRAM read address
- `mem_re_o`  out  1  BRAM read enable
- `mem_data_i`  in  N  BRAM read data, valid 1 cycle after `mem_re_o`
- `activation_data_o`  out  N signed  element to the convolution layer
- `run_o`  out  1  `activation_data_o` valid this cycle
- `busy_o`  out  1  high from accepted start until `done_o` inclusive
- `done_o`  out  1  one-cycle pulse after the last element

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start_i`=1 latches M, p and base, clears row/col/addr counters, and moves to ISSUE.
  - If M=0, it moves to DRAIN instead.
- Padded edge P = M+2p, 15 bits. Row and col counters each span 0..P-1; col wraps to 0 and increments row.
- An element is padding when row<p, row≥p+M, col<p, or col≥p+M.
- ISSUE, one element per cycle when `hold_i`=0:
  - Padding element: `mem_re_o`=0, and the stage-1 zero flag is set.
  - Interior element: `mem_re_o`=1 with `mem_addr_o`=addr, then addr increments. Address arithmetic wraps mod 2^AddrBits.
  - `hold_i`=1: no issue, and the counters freeze.
  - Issuing element (P-1,P-1) moves the FSM to DRAIN.
- Stage 1, the output register:
  - It is loaded the cycle after an issue, with 0 for a padding element or `mem_data_i` otherwise, and `run_o`=1.
  - In cycles with no preceding issue: `run_o`=0 and `activation_data_o` holds its last value.
- DRAIN: one cycle while the final element is presented, then DONE.
- DONE: `done_o`=1 for one cycle, then IDLE.
- `start_i` outside IDLE is ignored. Input changes after an accepted start have no effect until the next start.
- Exactly M² memory reads and P² `run_o` cycles per run, for M>0.

## Timing
- Reset values: FSM IDLE; `run_o`, `mem_re_o`, `busy_o`, `done_o` = 0; `activation_data_o`, `mem_addr_o` = 0.
- Latency:
  - Start sampled at edge 0.
  - First issue in cycle 1.
  - First `run_o` in cycle 2.
  - With no holds, P² consecutive `run_o` cycles follow.
  - `done_o` comes in the cycle after the last `run_o`.
- Hold:
  - `hold_i` in cycle t suppresses the issue in t, so `run_o`=0 in t+1.
  - The element issued in t-1 is still presented in t.
  - Gaps appear exactly one cycle after hold cycles.
- `hold_i` during DRAIN/DONE has no effect.
- `rst_i`=0 at any edge, mid-stream included, forces the reset values at that edge. There is no partial completion and no `done_o`.
- Simultaneous `rst_i`=0 and `start_i`=1: reset wins.
- `busy_o` is combinational from state (≠IDLE).

## Structure
- `activation_streamer_pkg`:
  - state enum
  - `MatrixBits`=14, `PadBits`=2, `EdgeBits`=15
- Sub-module `pad_index_gen`:
  - row/col counters with advance and clear
  - emits `is_pad` and `last`
- The top level holds the FSM, the address counter and the stage-1 register.

## Test plan
- M=3, p=0, base=0x10, memory 1..9 → `run_o` high for cycles 2..10 with data 1..9; reads at 0x10..0x18; `done_o` at cycle 11.
- M=2, p=1, memory {5,6,7,8} → 16 outputs 0,0,0,0, 0,5,6,0, 0,7,8,0, 0,0,0,0; `mem_re_o` exactly 4 times, addresses base..base+3.
- M=3, p=0, `hold_i` high for 2 cycles after the 4th issue → 1..9 in order; exactly 2 `run_o`=0 gaps, `activation_data_o` held at 4; `done_o` 2 cycles later than nominal.
- `start_i` pulsed with M=5 during a running M=3 job → ignored; 9 outputs, a single `done_o`.
- M=0, p=2 → no `run_o`, no `mem_re_o`; `busy_o` high for cycles 1..2, `done_o` at cycle 2.
- `rst_i`=0 for one cycle after the 5th output of M=3 → all outputs zero next edge, no `done_o`; a subsequent start produces 1..9 correctly.
